fifo_priority: RTL and testbench

- Two-queue synchronous priority FIFO: one high-priority (HP) queue and one low-priority (LP) queue, each with its own write port.
- Both queues share a single read port.
- A read always serves the HP queue when it holds data; otherwise it serves the LP queue.
- Sits between producers of urgent and background traffic and a single consumer.

---
 rtl/fifo_priority_pkg.sv | 32 +++
 rtl/sync_fifo_core.sv | 68 ++++++
 rtl/fifo_priority.sv | 85 ++++++++
 tb/tb_fifo_priority.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_priority_pkg.sv
// Shared defaults and read-arbitration helper for the two-queue priority FIFO.
// Imported by sync_fifo_core and fifo_priority.
package fifo_priority_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    // Which queue, if any, a read strobe is served from this cycle.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_HP   = 2'd1,
        RD_LP   = 2'd2
    } rd_src_e;

    // HP always wins while it holds data; LP is served only when HP is empty.
    function automatic rd_src_e pick_source(input logic rd_en,
                                            input logic hp_empty,
                                            input logic lp_empty);
        rd_src_e src;
        src = RD_NONE;
        if (rd_en) begin
            if (!hp_empty) begin
                src = RD_HP;
            end else if (!lp_empty) begin
                src = RD_LP;
            end
        end
        return src;
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single circular-buffer FIFO: storage, wrap-around pointers, occupancy count
// and empty/full flags, with a combinational view of the head word.
module sync_fifo_core
    import fifo_priority_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  do_wr;
    logic                  do_rd;

    // Flags come from the pre-edge count, so a write to a full queue is
    // dropped even when the same cycle also reads that queue.
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign head  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_WIDTH'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_WIDTH'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is intentionally left out of reset; stale words are
    // unreachable once the pointers and count clear, and this keeps it a RAM.
    always_ff @(posedge clk) begin
        if (do_wr && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fifo_priority.sv
// Two-queue priority FIFO: independent HP/LP write ports, one shared read
// port that drains HP first, and a registered dout that holds between reads.
module fifo_priority
    import fifo_priority_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hp_wr_en,
    input  logic [DATA_WIDTH-1:0] hp_din,
    input  logic                  lp_wr_en,
    input  logic [DATA_WIDTH-1:0] lp_din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  hp_empty,
    output logic                  lp_empty,
    output logic                  hp_full,
    output logic                  lp_full
);

    rd_src_e               rd_src;
    logic                  hp_rd;
    logic                  lp_rd;
    logic [DATA_WIDTH-1:0] hp_head;
    logic [DATA_WIDTH-1:0] lp_head;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        rd_src = RD_NONE;
        hp_rd  = 1'b0;
        lp_rd  = 1'b0;
        rd_src = pick_source(rd_en, hp_empty, lp_empty);
        hp_rd  = (rd_src == RD_HP);
        lp_rd  = (rd_src == RD_LP);
    end

    sync_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hp_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (hp_wr_en),
        .din   (hp_din),
        .rd_en (hp_rd),
        .head  (hp_head),
        .empty (hp_empty),
        .full  (hp_full)
    );

    sync_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lp_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (lp_wr_en),
        .din   (lp_din),
        .rd_en (lp_rd),
        .head  (lp_head),
        .empty (lp_empty),
        .full  (lp_full)
    );

    // A write into an empty queue is never forwarded: arbitration only sees
    // words already stored before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            case (rd_src)
                RD_HP:   dout <= hp_head;
                RD_LP:   dout <= lp_head;
                default: dout <= dout;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_priority.sv
// Self-checking bench for fifo_priority: directed scenarios plus random
// traffic, compared against a queue-based reference model.
module tb_fifo_priority;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          hp_wr_en;
    logic [DW-1:0] hp_din;
    logic          lp_wr_en;
    logic [DW-1:0] lp_din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          hp_empty;
    logic          lp_empty;
    logic          hp_full;
    logic          lp_full;

    logic [DW-1:0] hp_q[$];
    logic [DW-1:0] lp_q[$];
    logic [DW-1:0] exp_dout;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    fifo_priority #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hp_wr_en (hp_wr_en),
        .hp_din   (hp_din),
        .lp_wr_en (lp_wr_en),
        .lp_din   (lp_din),
        .rd_en    (rd_en),
        .dout     (dout),
        .hp_empty (hp_empty),
        .lp_empty (lp_empty),
        .hp_full  (hp_full),
        .lp_full  (lp_full)
    );

    // One clock: drive inputs, advance the model with pre-edge occupancy,
    // then settle 1 time unit past the edge so outputs can be sampled.
    task automatic step(input logic hw, input logic [DW-1:0] hd,
                        input logic lw, input logic [DW-1:0] ld,
                        input logic re, input logic r = 1'b0);
        bit hp_full_pre;
        bit lp_full_pre;
        hp_full_pre = (hp_q.size() == DEPTH);
        lp_full_pre = (lp_q.size() == DEPTH);
        rst = r; hp_wr_en = hw; hp_din = hd; lp_wr_en = lw; lp_din = ld; rd_en = re;
        if (r) begin
            hp_q.delete();
            lp_q.delete();
            exp_dout = '0;
        end else begin
            if (re) begin
                if (hp_q.size() > 0)      exp_dout = hp_q.pop_front();
                else if (lp_q.size() > 0) exp_dout = lp_q.pop_front();
            end
            if (hw && !hp_full_pre) hp_q.push_back(hd);
            if (lw && !lp_full_pre) lp_q.push_back(ld);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; hp_wr_en = 1'b0; lp_wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 1'b1);
        checks++;
        if ({dout, hp_empty, lp_empty, hp_full, lp_full} !== {16'h0000, 4'b1100}) begin
            errors++;
            $display("FAIL reset: got dout=%h he=%b le=%b hf=%b lf=%b, expected dout=0000 he=1 le=1 hf=0 lf=0",
                     dout, hp_empty, lp_empty, hp_full, lp_full);
        end
    endtask

    task automatic test_priority();
        logic [DW-1:0] lp_vals [3] = '{16'hA124, 16'hA267, 16'hA3B4};
        logic [DW-1:0] hp_vals [2] = '{16'hB1B5, 16'hB278};
        logic [DW-1:0] exp_seq [6] = '{16'hB1B5, 16'hB278, 16'hA124, 16'hA267, 16'hA3B4, 16'hA3B4};
        foreach (lp_vals[i]) step(1'b0, '0, 1'b1, lp_vals[i], 1'b0);
        foreach (hp_vals[i]) step(1'b1, hp_vals[i], 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b1);
            checks++;
            if (dout !== exp_seq[i]) begin
                errors++;
                $display("FAIL priority_read%0d: got %h expected %h", i, dout, exp_seq[i]);
            end
        end
        checks++;
        if ({hp_empty, lp_empty} !== 2'b11) begin
            errors++;
            $display("FAIL priority_empty: got he=%b le=%b expected 1 1", hp_empty, lp_empty);
        end
    endtask

    task automatic test_lp_overflow();
        logic [DW-1:0] lp_vals [10] = '{16'hD1D1, 16'hA222, 16'hA3B3, 16'h2224, 16'h33B5,
                                        16'hA226, 16'hA3B7, 16'hC128, 16'hD9D9, 16'hDDDD};
        logic [DW-1:0] exp_seq [12] = '{16'hC1F6, 16'hD1D1, 16'hA222, 16'hA3B3, 16'h2224, 16'h33B5,
                                        16'hA226, 16'hA3B7, 16'hC128, 16'hC128, 16'hC128, 16'hC128};
        step(1'b1, 16'hC1F6, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1, lp_vals[i], 1'b0);
            checks++;
            if (lp_full !== (i >= 7)) begin
                errors++;
                $display("FAIL lp_full_after_write%0d: got %b expected %b", i + 1, lp_full, (i >= 7));
            end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b1);
            checks++;
            if (dout !== exp_seq[i]) begin
                errors++;
                $display("FAIL overflow_read%0d: got %h expected %h", i, dout, exp_seq[i]);
            end
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, DW'(16'h5000 + r * 16 + i), 1'b0);
            for (int i = 0; i < DEPTH; i++) begin
                step(1'b0, '0, 1'b0, '0, 1'b1);
                checks++;
                if (dout !== DW'(16'h5000 + r * 16 + i)) begin
                    errors++;
                    $display("FAIL wrap_r%0d_i%0d: got %h expected %h", r, i, dout, DW'(16'h5000 + r * 16 + i));
                end
            end
        end
    endtask

    // Write into an empty queue while reading: the new word must not be
    // forwarded, so dout holds.
    task automatic test_no_forward();
        logic [DW-1:0] held;
        held = exp_dout;
        step(1'b1, 16'h7E57, 1'b0, '0, 1'b1);
        checks++;
        if (dout !== held) begin
            errors++;
            $display("FAIL no_forward: got %h expected %h", dout, held);
        end
        step(1'b0, '0, 1'b0, '0, 1'b1);
        checks++;
        if (dout !== 16'h7E57) begin
            errors++;
            $display("FAIL no_forward_next: got %h expected 7e57", dout);
        end
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'($urandom), 1'b0, '0, 1'b1);
            checks++;
            if ({dout, hp_empty, hp_full} !== {exp_dout, 2'b00}) begin
                errors++;
                $display("FAIL concurrent%0d: got dout=%h he=%b hf=%b expected dout=%h he=0 hf=0",
                         i, dout, hp_empty, hp_full, exp_dout);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, '0, 1'b1);
            checks++;
            if (dout !== exp_dout) begin
                errors++;
                $display("FAIL concurrent_drain%0d: got %h expected %h", i, dout, exp_dout);
            end
        end
        checks++;
        if (hp_empty !== 1'b1) begin
            errors++;
            $display("FAIL concurrent_final_empty: got %b expected 1", hp_empty);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(i < 2, DW'($urandom), 1'b1, DW'($urandom), 1'b0);
        step(1'b1, 16'hFFFF, 1'b1, 16'hEEEE, 1'b1, 1'b1);
        checks++;
        if ({dout, hp_empty, lp_empty} !== {16'h0000, 2'b11}) begin
            errors++;
            $display("FAIL reset_mid: got dout=%h he=%b le=%b expected 0000 1 1", dout, hp_empty, lp_empty);
        end
        step(1'b0, '0, 1'b0, '0, 1'b1);
        checks++;
        if ({dout, hp_empty, lp_empty} !== {16'h0000, 2'b11}) begin
            errors++;
            $display("FAIL reset_mid_read: got dout=%h he=%b le=%b expected 0000 1 1", dout, hp_empty, lp_empty);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, DW'($urandom),
                 $urandom_range(0, 2) != 0, DW'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
            checks++;
            if ({dout, hp_empty, lp_empty, hp_full, lp_full} !==
                {exp_dout, hp_q.size() == 0, lp_q.size() == 0,
                 hp_q.size() == DEPTH, lp_q.size() == DEPTH}) begin
                errors++;
                $display("FAIL random%0d: got dout=%h he=%b le=%b hf=%b lf=%b expected dout=%h hp_cnt=%0d lp_cnt=%0d",
                         i, dout, hp_empty, lp_empty, hp_full, lp_full, exp_dout, hp_q.size(), lp_q.size());
            end
        end
    endtask

    initial begin
        rst = 1'b1; hp_wr_en = 1'b0; hp_din = '0; lp_wr_en = 1'b0; lp_din = '0; rd_en = 1'b0;
        exp_dout = '0;
        test_reset();
        test_priority();
        test_lp_overflow();
        test_wrap();
        test_no_forward();
        test_concurrent();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
